alsu_arbiter: RTL and testbench

ALSU_ARBITER -- requirements
Module: alsu_arbiter

---
 rtl/alsu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alsu_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency ALSU: accepts a command word,
// issues it, waits LAT edges and returns the result. Optional check: ALSU_ARB_CMD_CHECK_EN.
module alsu_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic [1:0]  rsp_valid,
    output logic [5:0]  rsp_data,
    output logic        rsp_err,
    output logic [2:0]  alsu_opcode,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_direction,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    input  logic [5:0]  alsu_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        ptr;
    logic        granted;
    logic [15:0] cmd_reg;
    logic [15:0] alsu_reg;
    logic [2:0]  cnt;
    logic [5:0]  data_reg;

    logic        any_valid;
    logic        sel;
    logic [15:0] sel_cmd;
    logic        sel_illegal;

    // When both requesters are pending, the one not granted last time wins.
    assign any_valid = |req_valid;
    assign sel       = (&req_valid) ? ~ptr : req_valid[1];
    assign sel_cmd   = sel ? cmd1 : cmd0;

`ifdef ALSU_ARB_CMD_CHECK_EN
    logic err_reg;

    function automatic logic cmd_illegal(input logic [15:0] c);
        logic [2:0] op;
        op = c[15:13];
        return (op == 3'b110) || (op == 3'b111) ||
               ((c[3] | c[2]) && (op != 3'b000) && (op != 3'b001));
    endfunction

    assign sel_illegal = cmd_illegal(sel_cmd);
    assign rsp_err     = (state == RESP) && err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((state == IDLE) && any_valid) begin
            err_reg <= sel_illegal;
        end
    end
`else
    assign sel_illegal = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = sel_illegal ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // alsu_reg only changes on the ISSUE edge, keeping shift/rotate inputs stable while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b1;
            granted  <= 1'b0;
            cmd_reg  <= '0;
            alsu_reg <= '0;
            cnt      <= '0;
            data_reg <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        ptr     <= sel;
                        granted <= sel;
                        cmd_reg <= sel_cmd;
                        if (sel_illegal) begin
                            data_reg <= '0;
                        end
                    end
                end
                ISSUE: begin
                    alsu_reg <= cmd_reg;
                    cnt      <= 3'(LAT - 1);
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        data_reg <= alsu_out;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = ((state == IDLE) && any_valid && !rst) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state == RESP) ? (granted ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_reg;
    assign busy      = (state != IDLE);

    assign alsu_opcode    = alsu_reg[15:13];
    assign alsu_A         = alsu_reg[12:10];
    assign alsu_B         = alsu_reg[9:7];
    assign alsu_cin       = alsu_reg[6];
    assign alsu_serial_in = alsu_reg[5];
    assign alsu_direction = alsu_reg[4];
    assign alsu_red_op_A  = alsu_reg[3];
    assign alsu_red_op_B  = alsu_reg[2];
    assign alsu_bypass_A  = alsu_reg[1];
    assign alsu_bypass_B  = alsu_reg[0];

endmodule

// File: tb/tb_alsu_arbiter.sv
// Scoreboard bench for alsu_arbiter: two instances (LAT=2 and LAT=3) each driving a
// behavioural ALSU model; expectations are hand-computed and queued at issue time.
module tb_alsu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc = cyc + 1;

    localparam logic [15:0] C_AND    = {3'd0, 3'd7, 3'd3, 7'b0000000};
    localparam logic [15:0] C_SHL    = {3'd4, 3'd0, 3'd0, 7'b0110000};
    localparam logic [15:0] C_XOR    = {3'd1, 3'd5, 3'd2, 7'b0000000};
    localparam logic [15:0] C_ADD    = {3'd2, 3'd6, 3'd3, 7'b1000000};
    localparam logic [15:0] C_AND2   = {3'd0, 3'd5, 3'd6, 7'b0000000};
    localparam logic [15:0] C_ILL    = {3'd7, 3'd0, 3'd0, 7'b0000000};
    localparam logic [15:0] C_REDBAD = {3'd2, 3'd1, 3'd1, 7'b0001000};
    localparam logic [15:0] C_REDOK  = {3'd0, 3'd7, 3'd0, 7'b0001000};
    localparam logic [15:0] C_MUL    = {3'd3, 3'd7, 3'd5, 7'b0000000};

    // Instance with LAT=2
    logic [1:0]  req_valid_2 = '0, req_ready_2, rsp_valid_2;
    logic [15:0] cmd0_2 = '0, cmd1_2 = '0;
    logic [5:0]  rsp_data_2, alsu_out_2;
    logic        rsp_err_2, busy_2;
    logic [2:0]  alsu_opcode_2, alsu_A_2, alsu_B_2;
    logic        alsu_cin_2, alsu_serial_in_2, alsu_direction_2, alsu_red_op_A_2;
    logic        alsu_red_op_B_2, alsu_bypass_A_2, alsu_bypass_B_2;

    // Instance with LAT=3
    logic [1:0]  req_valid_3 = '0, req_ready_3, rsp_valid_3;
    logic [15:0] cmd0_3 = '0, cmd1_3 = '0;
    logic [5:0]  rsp_data_3, alsu_out_3;
    logic        rsp_err_3, busy_3;
    logic [2:0]  alsu_opcode_3, alsu_A_3, alsu_B_3;
    logic        alsu_cin_3, alsu_serial_in_3, alsu_direction_3, alsu_red_op_A_3;
    logic        alsu_red_op_B_3, alsu_bypass_A_3, alsu_bypass_B_3;

    alsu_arbiter #(.LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid_2), .req_ready(req_ready_2),
        .cmd0(cmd0_2), .cmd1(cmd1_2), .rsp_valid(rsp_valid_2), .rsp_data(rsp_data_2),
        .rsp_err(rsp_err_2), .alsu_opcode(alsu_opcode_2), .alsu_A(alsu_A_2), .alsu_B(alsu_B_2),
        .alsu_cin(alsu_cin_2), .alsu_serial_in(alsu_serial_in_2), .alsu_direction(alsu_direction_2),
        .alsu_red_op_A(alsu_red_op_A_2), .alsu_red_op_B(alsu_red_op_B_2),
        .alsu_bypass_A(alsu_bypass_A_2), .alsu_bypass_B(alsu_bypass_B_2),
        .alsu_out(alsu_out_2), .busy(busy_2)
    );

    alsu_arbiter #(.LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid_3), .req_ready(req_ready_3),
        .cmd0(cmd0_3), .cmd1(cmd1_3), .rsp_valid(rsp_valid_3), .rsp_data(rsp_data_3),
        .rsp_err(rsp_err_3), .alsu_opcode(alsu_opcode_3), .alsu_A(alsu_A_3), .alsu_B(alsu_B_3),
        .alsu_cin(alsu_cin_3), .alsu_serial_in(alsu_serial_in_3), .alsu_direction(alsu_direction_3),
        .alsu_red_op_A(alsu_red_op_A_3), .alsu_red_op_B(alsu_red_op_B_3),
        .alsu_bypass_A(alsu_bypass_A_3), .alsu_bypass_B(alsu_bypass_B_3),
        .alsu_out(alsu_out_3), .busy(busy_3)
    );

    logic [15:0] bun2, bun3;
    assign bun2 = {alsu_opcode_2, alsu_A_2, alsu_B_2, alsu_cin_2, alsu_serial_in_2, alsu_direction_2,
                   alsu_red_op_A_2, alsu_red_op_B_2, alsu_bypass_A_2, alsu_bypass_B_2};
    assign bun3 = {alsu_opcode_3, alsu_A_3, alsu_B_3, alsu_cin_3, alsu_serial_in_3, alsu_direction_3,
                   alsu_red_op_A_3, alsu_red_op_B_3, alsu_bypass_A_3, alsu_bypass_B_3};

    // Behavioural ALSU; shift/rotate operate on the last delivered result.
    function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] acc);
        logic [2:0] op, a, b;
        op = c[15:13];
        a  = c[12:10];
        b  = c[9:7];
        if (c[1]) return {3'b000, a};
        if (c[0]) return {3'b000, b};
        case (op)
            3'd0:    return c[3] ? {5'b0, &a} : (c[2] ? {5'b0, &b} : {3'b000, a & b});
            3'd1:    return c[3] ? {5'b0, ^a} : (c[2] ? {5'b0, ^b} : {3'b000, a ^ b});
            3'd2:    return 6'(a) + 6'(b) + 6'(c[6]);
            3'd3:    return 6'(a) * 6'(b);
            3'd4:    return c[4] ? {acc[4:0], c[5]} : {c[5], acc[5:1]};
            3'd5:    return c[4] ? {acc[4:0], acc[5]} : {acc[0], acc[5:1]};
            default: return 6'd0;
        endcase
    endfunction

    logic [5:0] p2, acc2, p3a, p3b, acc3;
    assign alsu_out_2 = p2;
    assign alsu_out_3 = p3b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p2 <= '0; acc2 <= '0; p3a <= '0; p3b <= '0; acc3 <= '0;
        end else begin
            p2  <= alsu_f(bun2, acc2);
            p3a <= alsu_f(bun3, acc3);
            p3b <= p3a;
            if (rsp_valid_2 != 2'b00 && !rsp_err_2) acc2 <= p2;
            if (rsp_valid_3 != 2'b00 && !rsp_err_3) acc3 <= p3b;
        end
    end

    typedef struct {
        logic       idx;
        logic [5:0] data;
        logic       err;
        int         lat;
    } rsp_t;

    rsp_t q2[$], q3[$];
    logic gq2[$], gq3[$];
    int   gcyc2 = 0, gcyc3 = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input bit on3, input logic idx, input bit has_rsp,
                              input logic [5:0] d, input logic e, input int lat);
        rsp_t r;
        r.idx = idx; r.data = d; r.err = e; r.lat = lat;
        if (on3) begin
            gq3.push_back(idx);
            if (has_rsp) q3.push_back(r);
        end else begin
            gq2.push_back(idx);
            if (has_rsp) q2.push_back(r);
        end
    endtask

    // Monitors: compare every grant and every response against the queues.
    always @(negedge clk) begin
        rsp_t e;
        logic g;
        if (!rst) begin
            if (req_ready_2 != 2'b00) begin
                check_output("grant2_expected", 32'(gq2.size() > 0), 1);
                if (gq2.size() > 0) begin
                    g = gq2.pop_front();
                    check_output("grant2", 32'(req_ready_2), g ? 32'd2 : 32'd1);
                end
                gcyc2 = cyc;
            end
            if (rsp_valid_2 != 2'b00) begin
                check_output("rsp2_expected", 32'(q2.size() > 0), 1);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    check_output("rsp2_valid", 32'(rsp_valid_2), e.idx ? 32'd2 : 32'd1);
                    check_output("rsp2_data", 32'(rsp_data_2), 32'(e.data));
                    check_output("rsp2_err", 32'(rsp_err_2), 32'(e.err));
                    check_output("rsp2_latency", cyc - gcyc2, e.lat);
                end
            end
            if (req_ready_3 != 2'b00) begin
                check_output("grant3_expected", 32'(gq3.size() > 0), 1);
                if (gq3.size() > 0) begin
                    g = gq3.pop_front();
                    check_output("grant3", 32'(req_ready_3), g ? 32'd2 : 32'd1);
                end
                gcyc3 = cyc;
            end
            if (rsp_valid_3 != 2'b00) begin
                check_output("rsp3_expected", 32'(q3.size() > 0), 1);
                if (q3.size() > 0) begin
                    e = q3.pop_front();
                    check_output("rsp3_valid", 32'(rsp_valid_3), e.idx ? 32'd2 : 32'd1);
                    check_output("rsp3_data", 32'(rsp_data_3), 32'(e.data));
                    check_output("rsp3_err", 32'(rsp_err_3), 32'(e.err));
                    check_output("rsp3_latency", cyc - gcyc3, e.lat);
                end
            end
        end
    end

    task automatic wait_grant(input bit on3);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((on3 ? req_ready_3 : req_ready_2) != 2'b00) got = 1;
        end
        check_output(on3 ? "grant3_timeout" : "grant2_timeout", 32'(got), 1);
        @(posedge clk);
        #1;
        req_valid_2 = 2'b00;
        req_valid_3 = 2'b00;
    endtask

    task automatic wait_idle(input bit on3);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!(on3 ? busy_3 : busy_2)) got = 1;
        end
        check_output(on3 ? "idle3_timeout" : "idle2_timeout", 32'(got), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        check_output({name, "_dut2"}, {req_ready_2, rsp_valid_2, rsp_data_2, rsp_err_2, busy_2, bun2}, 0);
        check_output({name, "_dut3"}, {req_ready_3, rsp_valid_3, rsp_data_3, rsp_err_3, busy_3, bun3}, 0);
    endtask

    task automatic apply_stimulus();
        int n;
        // Reset with a request already pending; it must be granted right after release.
        req_valid_2 = 2'b01;
        cmd0_2      = C_AND;
        expect_txn(0, 1'b0, 1, 6'b000011, 1'b0, 4);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        wait_grant(0);
        wait_idle(0);

        // Single-step shift left of the previous result, inputs stable while waiting.
        cmd1_2      = C_SHL;
        req_valid_2 = 2'b10;
        expect_txn(0, 1'b1, 1, 6'b000111, 1'b0, 4);
        wait_grant(0);
        @(posedge clk);
        #1 check_output("alsu_hold_wait1", 32'(bun2), 32'(C_SHL));
        @(posedge clk);
        #1 check_output("alsu_hold_wait2", 32'(bun2), 32'(C_SHL));
        wait_idle(0);

        // Both requesters held: grants alternate 0,1,0,1.
        cmd0_2 = C_XOR;
        cmd1_2 = C_ADD;
        for (int i = 0; i < 2; i++) begin
            expect_txn(0, 1'b0, 1, 6'b000111, 1'b0, 4);
            expect_txn(0, 1'b1, 1, 6'b001010, 1'b0, 4);
        end
        req_valid_2 = 2'b11;
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (req_ready_2 != 2'b00) n++;
        end
        check_output("alternate_grant_count", n, 4);
        @(posedge clk);
        #1 req_valid_2 = 2'b00;
        wait_idle(0);

        // Reset during WAIT drops the command with no response.
        cmd0_2      = C_AND;
        req_valid_2 = 2'b01;
        expect_txn(0, 1'b0, 0, 6'd0, 1'b0, 0);
        wait_grant(0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_state("reset_mid_wait");
        @(posedge clk);
        #1 rst = 1'b0;
        cmd1_2      = C_AND2;
        req_valid_2 = 2'b10;
        expect_txn(0, 1'b1, 1, 6'b000100, 1'b0, 4);
        wait_grant(0);
        wait_idle(0);

        // Illegal opcode and illegal reduction, then a legal reduction.
        cmd0_2      = C_ILL;
        req_valid_2 = 2'b01;
`ifdef ALSU_ARB_CMD_CHECK_EN
        expect_txn(0, 1'b0, 1, 6'd0, 1'b1, 1);
`else
        expect_txn(0, 1'b0, 1, 6'd0, 1'b0, 4);
`endif
        wait_grant(0);
        wait_idle(0);
`ifdef ALSU_ARB_CMD_CHECK_EN
        check_output("alsu_untouched_illegal", 32'(bun2), 32'(C_AND2));
`else
        check_output("alsu_issued_illegal", 32'(bun2), 32'(C_ILL));
`endif
        cmd0_2      = C_REDBAD;
        req_valid_2 = 2'b01;
`ifdef ALSU_ARB_CMD_CHECK_EN
        expect_txn(0, 1'b0, 1, 6'd0, 1'b1, 1);
`else
        expect_txn(0, 1'b0, 1, 6'd2, 1'b0, 4);
`endif
        wait_grant(0);
        wait_idle(0);
        cmd0_2      = C_REDOK;
        req_valid_2 = 2'b01;
        expect_txn(0, 1'b0, 1, 6'd1, 1'b0, 4);
        wait_grant(0);
        wait_idle(0);

        // Multiply on the LAT=3 instance.
        cmd0_3      = C_MUL;
        req_valid_3 = 2'b01;
        expect_txn(1, 1'b0, 1, 6'b100011, 1'b0, 5);
        wait_grant(1);
        wait_idle(1);
    endtask

    initial begin
        $display("[TB] start");
        apply_stimulus();
        repeat (3) @(posedge clk);
        check_output("leftover_grants2", gq2.size(), 0);
        check_output("leftover_rsps2", q2.size(), 0);
        check_output("leftover_grants3", gq3.size(), 0);
        check_output("leftover_rsps3", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
